// File: rtl/data_io_pkg.sv
// rtl/data_io_pkg.sv - shared command codes and lane helper for the data_io_wide loader
// Purpose: constants shared by data_io_wide and its sub-modules.
//   UIO_FILE_TX      start (payload != 0) or end (payload == 0) of a download
//   UIO_FILE_TX_DAT  file payload bytes
//   UIO_FILE_INDEX   menu index of the file being downloaded
//   nb(dw)           number of byte lanes in a dw-bit word
package data_io_pkg;

  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

  function automatic int nb(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/data_io_fifo.sv
// rtl/data_io_fifo.sv - single-clock word FIFO between the packer and the ioctl write port
// Purpose: buffers packed words so ioctl_wait stalls do not lose data.
// Ports:
//   clk_sys, reset_n  clock and asynchronous active-low reset
//   wr_en, wr_data    push request; ignored when full unless a pop happens in the same cycle
//   rd_en             pop request; ignored when empty
//   rd_data           head entry (valid while !empty)
//   full, empty       occupancy flags
module data_io_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // A pop frees the slot the same cycle, so a push into a full FIFO is kept.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk_sys) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_io_wide.sv
// rtl/data_io_wide.sv - ARM SPI file download receiver packing bytes into DW-bit ioctl words
// Purpose: samples the ARM SPI link in clk_sys, decodes FILE_TX / FILE_TX_DAT / FILE_INDEX,
//   packs payload bytes little-endian into DW-bit words with byte enables, buffers them in
//   data_io_fifo and writes them out on the ioctl port, honouring ioctl_wait.
// Optional build macro: DATA_IO_WIDE_CHKSUM_EN enables the running byte sum on ioctl_chksum;
//   without it ioctl_chksum is tied to zero.
// Ports:
//   clk_sys, reset_n           system clock, asynchronous active-low reset
//   SPI_SCK, SPI_SS2, SPI_DI   asynchronous SPI from the ARM (SS2 active-low, MSB first)
//   ioctl_wait                 sink busy, holds off writes
//   ioctl_download             download in progress
//   ioctl_index                menu index of the file
//   ioctl_wr                   one-cycle write strobe with ioctl_addr/ioctl_dout/ioctl_be
//   ioctl_overflow             sticky, a word was dropped on a full FIFO
//   ioctl_chksum               running sum of payload bytes
module data_io_wide
  import data_io_pkg::*;
#(
  parameter int          DW         = 16,
  parameter int          AW         = 25,
  parameter logic [AW-1:0] BASE_ADDR = 'h804000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  input  logic              ioctl_wait,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [AW-1:0]     ioctl_addr,
  output logic [DW-1:0]     ioctl_dout,
  output logic [DW/8-1:0]   ioctl_be,
  output logic              ioctl_overflow,
  output logic [15:0]       ioctl_chksum
);

  localparam int NB = nb(DW);
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  // SPI synchronisers; sck_sr[2] is the previous synced value for edge detection.
  logic [2:0] sck_sr;
  logic [1:0] ss_sr;
  logic [1:0] di_sr;
  logic       sck_rise;
  logic       ss_hi;
  logic       di_s;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_sr <= '0;
      ss_sr  <= 2'b11;
      di_sr  <= '0;
    end else begin
      sck_sr <= {sck_sr[1:0], SPI_SCK};
      ss_sr  <= {ss_sr[0], SPI_SS2};
      di_sr  <= {di_sr[0], SPI_DI};
    end
  end

  assign sck_rise = sck_sr[1] && !sck_sr[2];
  assign ss_hi    = ss_sr[1];
  assign di_s     = di_sr[1];

  // Byte shifter. has_cmd marks that byte 0 (the command) of this transaction is in.
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic       has_cmd;
  logic [7:0] cmd;
  logic       byte_done;
  logic       pl_stb;
  logic [7:0] rx_byte;

  assign byte_done = sck_rise && !ss_hi && (bit_cnt == 3'd7);
  assign rx_byte   = {shift, di_s};
  assign pl_stb    = byte_done && has_cmd;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shift   <= '0;
      bit_cnt <= '0;
      has_cmd <= 1'b0;
      cmd     <= '0;
    end else if (ss_hi) begin
      bit_cnt <= '0;
      has_cmd <= 1'b0;
    end else if (sck_rise) begin
      shift   <= {shift[5:0], di_s};
      bit_cnt <= bit_cnt + 1'b1;
      if (byte_done && !has_cmd) begin
        cmd     <= rx_byte;
        has_cmd <= 1'b1;
      end
    end
  end

  // Packer: pack_data holds the lanes filled so far, upper lanes kept at zero so the
  // final partial word comes out zero-padded without extra masking.
  logic [LW-1:0] lane_cnt;
  logic [DW-1:0] pack_data;
  logic [DW-1:0] pack_merge;
  logic [NB-1:0] be_part;
  logic          lane_last;

  assign lane_last = (lane_cnt == LW'(NB - 1));

  always_comb begin
    pack_merge = pack_data;
    pack_merge[8*int'(lane_cnt) +: 8] = rx_byte;
    be_part = '0;
    for (int k = 0; k < NB; k++) begin
      be_part[k] = (k < int'(lane_cnt));
    end
  end

  // FIFO interface
  logic                 push_vld;
  logic [DW+NB-1:0]     push_word;
  logic [DW+NB-1:0]     fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic [AW-1:0]        addr_cnt;
  logic                 end_pend;

  assign pop = !fifo_empty && !ioctl_wait;

  data_io_fifo #(
    .W     (DW + NB),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .wr_en   (push_vld),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Command decode, packer update, address counter and write port. Later assignments
  // win, so a FILE_TX start in the same cycle overrides a drop or an end-of-file fall.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt       <= '0;
      pack_data      <= '0;
      push_vld       <= 1'b0;
      push_word      <= '0;
      addr_cnt       <= BASE_ADDR;
      end_pend       <= 1'b0;
      ioctl_download <= 1'b0;
      ioctl_index    <= '0;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      ioctl_be       <= '0;
      ioctl_overflow <= 1'b0;
    end else begin
      push_vld <= 1'b0;
      ioctl_wr <= pop;
      if (pop) begin
        ioctl_dout <= fifo_rdata[DW-1:0];
        ioctl_be   <= fifo_rdata[DW +: NB];
        ioctl_addr <= addr_cnt;
        addr_cnt   <= addr_cnt + AW'(NB);
      end
      if (push_vld && fifo_full && !pop) begin
        ioctl_overflow <= 1'b1;
      end
      // Nothing queued and nothing about to be queued: the last word has gone out.
      if (end_pend && fifo_empty && !push_vld) begin
        end_pend       <= 1'b0;
        ioctl_download <= 1'b0;
      end
      if (pl_stb) begin
        case (cmd)
          UIO_FILE_TX: begin
            if (rx_byte != 8'h00) begin
              ioctl_download <= 1'b1;
              end_pend       <= 1'b0;
              lane_cnt       <= '0;
              pack_data      <= '0;
              addr_cnt       <= BASE_ADDR;
              ioctl_overflow <= 1'b0;
            end else begin
              if (lane_cnt != '0) begin
                push_vld  <= 1'b1;
                push_word <= {be_part, pack_data};
              end
              lane_cnt  <= '0;
              pack_data <= '0;
              end_pend  <= 1'b1;
            end
          end
          UIO_FILE_TX_DAT: begin
            if (lane_last) begin
              push_vld  <= 1'b1;
              push_word <= {{NB{1'b1}}, pack_merge};
              pack_data <= '0;
              lane_cnt  <= '0;
            end else begin
              pack_data <= pack_merge;
              lane_cnt  <= lane_cnt + 1'b1;
            end
          end
          UIO_FILE_INDEX: ioctl_index <= rx_byte;
          default: ;
        endcase
      end
    end
  end

`ifdef DATA_IO_WIDE_CHKSUM_EN
  logic [15:0] chksum;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      chksum <= '0;
    end else if (pl_stb) begin
      if (cmd == UIO_FILE_TX && rx_byte != 8'h00) begin
        chksum <= '0;
      end else if (cmd == UIO_FILE_TX_DAT) begin
        chksum <= chksum + {8'h00, rx_byte};
      end
    end
  end

  assign ioctl_chksum = chksum;
`else
  assign ioctl_chksum = 16'h0000;
`endif

endmodule

// File: tb/tb_data_io_wide.sv
// tb/tb_data_io_wide.sv - self-checking bench for data_io_wide at DW=16 and DW=32
module tb_data_io_wide;
  import data_io_pkg::*;

  localparam logic [24:0] BASE = 25'h804000;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic sck = 1'b0;
  logic ss2 = 1'b1;
  logic di = 1'b0;
  logic io_wait = 1'b0;

  always #5 clk_sys = ~clk_sys;

  logic        dl16, wr16, ovf16;
  logic [7:0]  idx16;
  logic [24:0] addr16;
  logic [15:0] dout16, chk16;
  logic [1:0]  be16;

  logic        dl32, wr32, ovf32;
  logic [7:0]  idx32;
  logic [24:0] addr32;
  logic [31:0] dout32;
  logic [15:0] chk32;
  logic [3:0]  be32;

  data_io_wide #(.DW(16)) dut16 (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .ioctl_wait(io_wait), .ioctl_download(dl16), .ioctl_index(idx16), .ioctl_wr(wr16),
    .ioctl_addr(addr16), .ioctl_dout(dout16), .ioctl_be(be16), .ioctl_overflow(ovf16),
    .ioctl_chksum(chk16)
  );

  data_io_wide #(.DW(32)) dut32 (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .ioctl_wait(io_wait), .ioctl_download(dl32), .ioctl_index(idx32), .ioctl_wr(wr32),
    .ioctl_addr(addr32), .ioctl_dout(dout32), .ioctl_be(be32), .ioctl_overflow(ovf32),
    .ioctl_chksum(chk32)
  );

  typedef struct {
    logic [24:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [7:0]  cmd;
    int          n;
    logic [95:0] pl;
    logic        hold;
    logic [7:0]  x_idx;
    logic        x_dl;
    logic        x_ovf16;
    logic        x_ovf32;
    logic [15:0] x_chk;
  } vec_t;

  wr_t q16[$];
  wr_t q32[$];
  int  n_checks = 0;
  int  n_fail = 0;

  // Byte-level reference packer, one per DUT width (index 0: DW=16, index 1: DW=32).
  int          nbw[2] = '{2, 4};
  int          m_lane[2];
  logic [31:0] m_word[2];
  logic [24:0] m_addr[2];
  int          m_occ[2];
  logic        hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_lane[d] = 0;
      m_word[d] = '0;
      m_addr[d] = BASE;
      m_occ[d]  = 0;
    end
  endtask

  task automatic m_push(input int d, input logic [31:0] w, input logic [3:0] be);
    wr_t e;
    if (hold && m_occ[d] >= 4) return;
    e.addr = m_addr[d];
    e.data = w;
    e.be   = be;
    if (d == 0) q16.push_back(e);
    else        q32.push_back(e);
    m_addr[d] = m_addr[d] + 25'(nbw[d]);
    if (hold) m_occ[d]++;
  endtask

  task automatic m_payload(input logic [7:0] cmd, input logic [7:0] b);
    for (int d = 0; d < 2; d++) begin
      if (cmd == UIO_FILE_TX && b != 8'h00) begin
        m_lane[d] = 0;
        m_word[d] = '0;
        m_addr[d] = BASE;
      end else if (cmd == UIO_FILE_TX) begin
        if (m_lane[d] != 0) m_push(d, m_word[d], 4'((1 << m_lane[d]) - 1));
        m_lane[d] = 0;
        m_word[d] = '0;
      end else if (cmd == UIO_FILE_TX_DAT) begin
        m_word[d][8*m_lane[d] +: 8] = b;
        m_lane[d]++;
        if (m_lane[d] == nbw[d]) begin
          m_push(d, m_word[d], 4'((1 << nbw[d]) - 1));
          m_lane[d] = 0;
          m_word[d] = '0;
        end
      end
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      di = b[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  // Expectations go to the scoreboard before each byte is shifted out.
  task automatic spi_txn(input logic [7:0] cmd, input int n, input logic [95:0] pl);
    logic [7:0] b;
    ss2 = 1'b0;
    #40;
    spi_bits(cmd, 8);
    for (int i = 0; i < n; i++) begin
      b = pl[8*(n-1-i) +: 8];
      m_payload(cmd, b);
      spi_bits(b, 8);
    end
    #40 ss2 = 1'b1;
    #160;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dl16"},   32'(dl16),   32'd0);
    check({tag, "_idx16"},  32'(idx16),  32'd0);
    check({tag, "_wr16"},   32'(wr16),   32'd0);
    check({tag, "_addr16"}, 32'(addr16), 32'd0);
    check({tag, "_dout16"}, 32'(dout16), 32'd0);
    check({tag, "_be16"},   32'(be16),   32'd0);
    check({tag, "_ovf16"},  32'(ovf16),  32'd0);
    check({tag, "_chk16"},  32'(chk16),  32'd0);
    check({tag, "_dl32"},   32'(dl32),   32'd0);
    check({tag, "_wr32"},   32'(wr32),   32'd0);
    check({tag, "_dout32"}, dout32,      32'd0);
    check({tag, "_ovf32"},  32'(ovf32),  32'd0);
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input int n, input logic [95:0] pl,
                              input logic hold_w, input logic [7:0] idx, input logic dl,
                              input logic o16, input logic o32, input logic [15:0] chk);
    vec_t v;
    v.cmd = cmd; v.n = n; v.pl = pl; v.hold = hold_w;
    v.x_idx = idx; v.x_dl = dl; v.x_ovf16 = o16; v.x_ovf32 = o32; v.x_chk = chk;
    return v;
  endfunction

  always @(negedge clk_sys) begin
    wr_t e;
    if (reset_n && wr16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr16_unexpected: got write %h@%h, expected no write", dout16, addr16);
      end else begin
        e = q16.pop_front();
        check("wr16_addr", 32'(addr16), 32'(e.addr));
        check("wr16_data", 32'(dout16), 32'(e.data[15:0]));
        check("wr16_be",   32'(be16),   32'(e.be[1:0]));
        check("wr16_dl",   32'(dl16),   32'd1);
      end
    end
    if (reset_n && wr32 === 1'b1) begin
      if (q32.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr32_unexpected: got write %h@%h, expected no write", dout32, addr32);
      end else begin
        e = q32.pop_front();
        check("wr32_addr", 32'(addr32), 32'(e.addr));
        check("wr32_data", dout32,      e.data);
        check("wr32_be",   32'(be32),   32'(e.be));
        check("wr32_dl",   32'(dl32),   32'd1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    logic [15:0] xc;

    vt[0]  = mk(8'h53, 1,  96'h01,                       1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
    vt[1]  = mk(8'h54, 4,  96'h11223344,                 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h00AA);
    vt[2]  = mk(8'h53, 1,  96'h00,                       1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h00AA);
    vt[3]  = mk(8'h53, 1,  96'h01,                       1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
    vt[4]  = mk(8'h54, 5,  96'hAABBCCDDEE,               1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h03FC);
    vt[5]  = mk(8'h53, 1,  96'h00,                       1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h03FC);
    vt[6]  = mk(8'h55, 1,  96'h03,                       1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 16'h03FC);
    vt[7]  = mk(8'h60, 2,  96'h1234,                     1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 16'h03FC);
    vt[8]  = mk(8'h53, 1,  96'h01,                       1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 16'h0000);
    vt[9]  = mk(8'h54, 12, 96'h0102030405060708090A0B0C, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 16'h004E);
    vt[10] = mk(8'h53, 1,  96'h00,                       1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 16'h004E);
    vt[11] = mk(8'h53, 1,  96'h01,                       1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 16'h0000);
    vt[12] = mk(8'h54, 2,  96'hFF02,                     1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 16'h0101);
    vt[13] = mk(8'h53, 1,  96'h00,                       1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 16'h0101);

    m_reset();
    repeat (4) @(negedge clk_sys);
    check_idle("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);

    for (int i = 0; i < 14; i++) begin
      hold    = vt[i].hold;
      io_wait = vt[i].hold;
      m_occ[0] = 0;
      m_occ[1] = 0;
      spi_txn(vt[i].cmd, vt[i].n, vt[i].pl);
      io_wait = 1'b0;
      hold    = 1'b0;
      repeat (60) @(negedge clk_sys);
`ifdef DATA_IO_WIDE_CHKSUM_EN
      xc = vt[i].x_chk;
`else
      xc = 16'h0000;
`endif
      check($sformatf("v%0d_idx16", i), 32'(idx16), 32'(vt[i].x_idx));
      check($sformatf("v%0d_idx32", i), 32'(idx32), 32'(vt[i].x_idx));
      check($sformatf("v%0d_dl16", i),  32'(dl16),  32'(vt[i].x_dl));
      check($sformatf("v%0d_dl32", i),  32'(dl32),  32'(vt[i].x_dl));
      check($sformatf("v%0d_ovf16", i), 32'(ovf16), 32'(vt[i].x_ovf16));
      check($sformatf("v%0d_ovf32", i), 32'(ovf32), 32'(vt[i].x_ovf32));
      check($sformatf("v%0d_chk16", i), 32'(chk16), 32'(xc));
      check($sformatf("v%0d_chk32", i), 32'(chk32), 32'(xc));
      check($sformatf("v%0d_q16", i),   q16.size(), 32'd0);
      check($sformatf("v%0d_q32", i),   q32.size(), 32'd0);
    end

    // SS2 raised mid-byte: the 5 shifted bits are discarded, packer lanes survive.
    spi_txn(8'h53, 1, 96'h01);
    ss2 = 1'b0;
    #40;
    spi_bits(8'h54, 8);
    spi_bits(8'hA5, 5);
    #40 ss2 = 1'b1;
    #160;
    spi_txn(8'h54, 2, 96'h7F80);
    spi_txn(8'h53, 1, 96'h00);
    repeat (60) @(negedge clk_sys);
    check("ss_dl16", 32'(dl16), 32'd0);
    check("ss_dl32", 32'(dl32), 32'd0);
    check("ss_q16", q16.size(), 32'd0);
    check("ss_q32", q32.size(), 32'd0);

    // Reset asserted in the middle of a file.
    spi_txn(8'h53, 1, 96'h01);
    spi_txn(8'h54, 3, 96'h010203);
    repeat (10) @(negedge clk_sys);
    check("mid_dl16", 32'(dl16), 32'd1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_idle("rst_mid");
    m_reset();
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    check_idle("post_rst");
    check("end_q16", q16.size(), 32'd0);
    check("end_q32", q32.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
